switch_bin_reader: RTL and testbench

//  Input-side counterpart of the LED binary display path: samples the board slide switches, debounces them, and

---
 rtl/sw_reader_pkg.sv | 12 +
 rtl/debounce_bit.sv | 49 ++++
 rtl/switch_bin_reader.sv | 96 +++++++++
 tb/tb_switch_bin_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_reader_pkg.sv
// Shared types and defaults for the switch-to-binary reader.
package sw_reader_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_REL
    } rd_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One asynchronous, bouncy input: synchronizer chain followed by a restart-on-glitch debounce counter.
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   synced;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
        synced   = sync_q[SYNC_STAGES-1];
        stable_d = stable_q;
        cnt_d    = '0;
        // Any sample equal to the accepted level restarts the count.
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/switch_bin_reader.sv
// Debounces the slide switches and load button, and hands a captured binary number
// to the consumer through a valid/ready handshake, one capture per button press.
module switch_bin_reader
    import sw_reader_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] binNum,
    output logic             num_valid,
    input  logic             num_ready
);

    logic             btn_db;
    logic             btn_q, btn_d;
    logic             press;
    rd_state_t        state_q, state_d;
    logic [WIDTH-1:0] bin_num_q, bin_num_d;
    logic             num_valid_q, num_valid_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sw_db
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sw_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw[i]),
            .stable(sw_stable[i])
        );
    end

    debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_load),
        .stable(btn_db)
    );

    always_comb begin
        btn_d       = btn_db;
        press       = btn_db & ~btn_q;
        state_d     = state_q;
        bin_num_d   = bin_num_q;
        num_valid_d = num_valid_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    bin_num_d   = sw_stable;
                    num_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // Presses here are dropped; the pending number must be consumed first.
                if (num_valid_q && num_ready) begin
                    num_valid_d = 1'b0;
                    state_d     = btn_db ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                if (!btn_db) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q       <= 1'b0;
            state_q     <= IDLE;
            bin_num_q   <= '0;
            num_valid_q <= 1'b0;
        end else begin
            btn_q       <= btn_d;
            state_q     <= state_d;
            bin_num_q   <= bin_num_d;
            num_valid_q <= num_valid_d;
        end
    end

    assign binNum    = bin_num_q;
    assign num_valid = num_valid_q;

endmodule

// File: tb/tb_switch_bin_reader.sv
// Scoreboard bench for switch_bin_reader: captures are queued at press time and checked at handshake.
module tb_switch_bin_reader;

    localparam int W   = 4;
    localparam int DC  = 4;
    localparam int SS  = 2;
    localparam int LAT = SS + DC;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         btn_load;
    logic [W-1:0] sw_stable;
    logic [W-1:0] binNum;
    logic         num_valid;
    logic         num_ready;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           hs_cnt   = 0;
    logic [W-1:0] exp_q[$];
    bit           rand_ready = 1'b0;

    int           chg;
    int           h0;
    logic         prev;
    logic [W-1:0] v;
    int           budget;

    always #5 clk = ~clk;

    switch_bin_reader #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_load (btn_load),
        .sw_stable(sw_stable),
        .binNum   (binNum),
        .num_valid(num_valid),
        .num_ready(num_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) num_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press_release(input int hold);
        btn_load = 1'b1;
        ticks(hold);
        btn_load = 1'b0;
        ticks(LAT + 3);
    endtask

    // Pops the oldest expected capture whenever the DUT completes a handshake at the coming edge.
    task automatic monitor();
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && num_valid && num_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_handshake: binNum=%0h with no capture expected", binNum);
                end else begin
                    e = exp_q.pop_front();
                    check("handshake_binNum", 32'(binNum), 32'(e));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset with every input asserted
        rst_n     = 1'b0;
        sw        = '1;
        btn_load  = 1'b1;
        num_ready = 1'b0;
        ticks(3);
        check("reset_sw_stable", 32'(sw_stable), 0);
        check("reset_binNum", 32'(binNum), 0);
        check("reset_num_valid", 32'(num_valid), 0);
        sw       = '0;
        btn_load = 1'b0;
        rst_n    = 1'b1;
        ticks(LAT + 4);
        check("idle_num_valid", 32'(num_valid), 0);

        // Clean capture with exact latency boundaries
        sw = 4'hA;
        ticks(LAT - 1);
        check("sw_stable_before_latency", 32'(sw_stable), 0);
        tick();
        check("sw_stable_at_latency", 32'(sw_stable), 32'hA);
        ticks(2);
        exp_q.push_back(4'hA);
        btn_load = 1'b1;
        ticks(LAT);
        check("num_valid_before_capture", 32'(num_valid), 0);
        tick();
        check("num_valid_at_capture", 32'(num_valid), 1);
        check("binNum_at_capture", 32'(binNum), 32'hA);
        ticks(3);
        btn_load = 1'b0;
        ticks(LAT + 3);
        check("num_valid_held", 32'(num_valid), 1);
        num_ready = 1'b1;
        tick();
        num_ready = 1'b0;
        check("num_valid_after_handshake", 32'(num_valid), 0);
        check("binNum_retained", 32'(binNum), 32'hA);
        check("queue_after_first", 32'(exp_q.size()), 0);

        // Bounce on sw[0]: only the final settle is accepted
        sw = 4'h0;
        ticks(LAT + 3);
        check("bounce_start_level", 32'(sw_stable), 0);
        chg  = 0;
        prev = sw_stable[0];
        for (int i = 0; i < 12; i++) begin
            sw[0] = ((i / 2) % 2) == 0;
            tick();
            if (sw_stable[0] != prev) chg++;
            prev = sw_stable[0];
        end
        sw[0] = 1'b1;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            if (sw_stable[0] != prev) chg++;
            prev = sw_stable[0];
            if (k == LAT - 1) check("bounce_before_latency", 32'(sw_stable[0]), 0);
            if (k == LAT) check("bounce_at_latency", 32'(sw_stable[0]), 1);
        end
        check("bounce_change_count", 32'(chg), 1);

        // Held button: one capture per press
        sw = 4'h5;
        ticks(LAT + 3);
        num_ready = 1'b1;
        h0 = hs_cnt;
        exp_q.push_back(4'h5);
        btn_load = 1'b1;
        ticks(30);
        check("held_one_handshake", 32'(hs_cnt - h0), 1);
        check("held_num_valid_low", 32'(num_valid), 0);
        btn_load = 1'b0;
        ticks(LAT + 3);
        check("release_no_capture", 32'(hs_cnt - h0), 1);
        exp_q.push_back(4'h5);
        press_release(10);
        check("second_press_capture", 32'(hs_cnt - h0), 2);
        num_ready = 1'b0;

        // Overwrite guard
        sw = 4'h3;
        ticks(LAT + 3);
        exp_q.push_back(4'h3);
        press_release(8);
        check("guard_first_valid", 32'(num_valid), 1);
        check("guard_first_binNum", 32'(binNum), 32'h3);
        sw = 4'hC;
        ticks(LAT + 3);
        check("guard_sw_stable_live", 32'(sw_stable), 32'hC);
        press_release(8);
        check("guard_no_overwrite", 32'(binNum), 32'h3);
        check("guard_still_valid", 32'(num_valid), 1);
        num_ready = 1'b1;
        tick();
        num_ready = 1'b0;
        check("guard_consumed", 32'(num_valid), 0);
        exp_q.push_back(4'hC);
        press_release(8);
        check("guard_new_capture", 32'(binNum), 32'hC);
        num_ready = 1'b1;
        tick();
        num_ready = 1'b0;
        ticks(2);

        // Reset while holding an unconsumed capture
        sw = 4'h6;
        ticks(LAT + 3);
        exp_q.push_back(4'h6);
        press_release(8);
        check("midreset_pre_valid", 32'(num_valid), 1);
        rst_n = 1'b0;
        tick();
        check("midreset_num_valid", 32'(num_valid), 0);
        check("midreset_binNum", 32'(binNum), 0);
        check("midreset_sw_stable", 32'(sw_stable), 0);
        exp_q.delete();
        ticks(2);
        rst_n = 1'b1;
        ticks(LAT + 3);
        check("post_reset_sw_stable", 32'(sw_stable), 32'h6);

        // Randomized presses with random consumer back-pressure
        rand_ready = 1'b1;
        repeat (25) begin
            v = W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                repeat (2) begin
                    sw = W'($urandom);
                    tick();
                end
            end
            sw = v;
            ticks(LAT + 2 + $urandom_range(0, 4));
            check("rand_sw_stable", 32'(sw_stable), 32'(v));
            btn_load = 1'b1;
            ticks(LAT);
            // The press pulse is live now; it captures only if nothing is pending.
            if (exp_q.size() == 0) exp_q.push_back(v);
            ticks($urandom_range(1, 12));
            btn_load = 1'b0;
            ticks(LAT + 2 + $urandom_range(0, 5));
        end
        rand_ready = 1'b0;
        num_ready  = 1'b1;
        budget     = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            tick();
            budget++;
        end
        check("final_queue_drained", 32'(exp_q.size()), 0);
        tick();
        check("final_num_valid", 32'(num_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
